// File: rtl/chunked_add_sub_seq.sv
// chunked_add_sub_seq: multi-cycle signed adder/subtractor that walks a
// w-bit operand pair k bits per clock, keeping the inter-chunk carry in a
// register so the combinational carry chain is only k bits long.
// Optional macro ADD_SUB_SATURATE_EN: clamp result to the signed limit on
// overflow (ovf and c_out still report the raw values).
module chunked_add_sub_seq #(
  parameter int w = 16,
  parameter int k = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [w-1:0] op1,
  input  logic [w-1:0] op2,
  input  logic         c_in,
  input  logic         sub,
  output logic         ready,
  output logic         done,
  output logic [w-1:0] result,
  output logic         c_out,
  output logic         ovf
);

  localparam int N  = w / k;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [w-1:0]  a_q, a_d;      // op1, shifted right one chunk per RUN cycle
  logic [w-1:0]  b_q, b_d;      // op2 (pre-inverted for sub), shifted likewise
  logic [w-1:0]  acc_q, acc_d;  // partial result, chunks enter at the top
  logic [w-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  // Current chunk always sits in the low k bits of the operand registers,
  // so no variable part-selects are needed.
  logic [k:0]     sum;
  logic           msb_cin;
  logic           ovf_raw;
  logic           last;
  logic [w+k-1:0] acc_cat, a_cat, b_cat;

  assign sum     = {1'b0, a_q[k-1:0]} + {1'b0, b_q[k-1:0]} + {{k{1'b0}}, carry_q};
  assign msb_cin = a_q[k-1] ^ b_q[k-1] ^ sum[k-1];  // carry into the chunk MSB
  assign ovf_raw = msb_cin ^ sum[k];
  assign last    = (cnt_q == CW'(N - 1));
  assign acc_cat = {sum[k-1:0], acc_q};
  assign a_cat   = {{k{1'b0}}, a_q};
  assign b_cat   = {{k{1'b0}}, b_q};

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = op1;
          b_d     = sub ? ~op2 : op2;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          acc_d   = '0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_cat[w+k-1:k];
        b_d     = b_cat[w+k-1:k];
        acc_d   = acc_cat[w+k-1:k];
        carry_d = sum[k];
        if (last) begin
          state_d = S_DONE;
          cout_d  = sum[k];
          ovf_d   = ovf_raw;
`ifdef ADD_SUB_SATURATE_EN
          // a_q[k-1] is the latched op1 MSB while the final chunk is live.
          if (ovf_raw)
            res_d = a_q[k-1] ? {1'b1, {(w-1){1'b0}}} : {1'b0, {(w-1){1'b1}}};
          else
            res_d = acc_cat[w+k-1:k];
`else
          res_d = acc_cat[w+k-1:k];
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready  = (state_q != S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign c_out  = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_chunked_add_sub_seq.sv
// Self-checking bench for chunked_add_sub_seq (w=16, k=4): directed cases
// plus randomized operations against an integer-arithmetic reference model.
module tb_chunked_add_sub_seq;
  localparam int W = 16;
  localparam int K = 4;
  localparam int N = W / K;

  logic         clk = 1'b0;
  logic         rst, start, c_in, sub;
  logic [W-1:0] op1, op2;
  logic         ready, done, c_out, ovf;
  logic [W-1:0] result;

  int errs   = 0;
  int checks = 0;

  // Last completed result, which the outputs must hold during RUN.
  logic [W-1:0] prev_r = '0;
  logic         prev_c = 1'b0;
  logic         prev_v = 1'b0;

  chunked_add_sub_seq #(.w(W), .k(K)) dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
    .c_in(c_in), .sub(sub), .ready(ready), .done(done),
    .result(result), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on whole operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic s, output logic [W-1:0] r, output logic co,
                       output logic ov);
    int     sa, sb, sr;
    longint ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'(a);
    ub = longint'(b);
    sr = s ? (sa - sb) : (sa + sb + int'(ci));
    ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    co = s ? (ua >= ub) : (((ua + ub + longint'(ci)) >> W) != 0);
    r  = sr[W-1:0];
`ifdef ADD_SUB_SATURATE_EN
    if (ov) r = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
  endtask

  // One operation: drive at negedge, accept at next edge, expect done N edges
  // later. With hold=1 start stays high and operands churn during RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic s, input logic hold);
    logic [W-1:0] er;
    logic         ec, ev;
    model(a, b, ci, s, er, ec, ev);
    @(negedge clk);
    start = 1'b1; op1 = a; op2 = b; c_in = ci; sub = s;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      start = hold;
      op1 = W'($urandom); op2 = W'($urandom);
      c_in = 1'($urandom); sub = 1'($urandom);
      chk("run_ready", 32'(ready), 32'd0);
      chk("run_done", 32'(done), 32'd0);
      chk("run_hold_result", 32'(result), 32'(prev_r));
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("done_ready", 32'(ready), 32'd1);
    chk("result", 32'(result), 32'(er));
    chk("c_out", 32'(c_out), 32'(ec));
    chk("ovf", 32'(ovf), 32'(ev));
    prev_r = er; prev_c = ec; prev_v = ev;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Directed cases from the test plan.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);   // back-to-back from DONE
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);   // negative overflow
    idle_cycle();
    // start held through RUN with churning operands.
    do_op(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b1);
    idle_cycle();

    // Reset mid-operation: rst on the 2nd RUN edge.
    @(negedge clk);
    start = 1'b1; op1 = 16'h7000; op2 = 16'h7000; c_in = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    prev_r = '0; prev_c = 1'b0; prev_v = 1'b0;
    for (int i = 0; i < N + 1; i++) idle_cycle();
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // rst and start together: rst wins, block stays idle.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op1 = 16'h1111; op2 = 16'h2222;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_result", 32'(result), 32'd0);
    prev_r = '0; prev_c = 1'b0; prev_v = 1'b0;
    idle_cycle();
    idle_cycle();

    // Randomized operations, sometimes back-to-back, sometimes with a gap.
    for (int t = 0; t < 60; t++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      if (t % 5 == 0) begin a[W-1] = 1'b0; b[W-1] = 1'b0; a[W-2] = 1'b1; b[W-2] = 1'b1; end
      do_op(a, b, 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
